// File: rtl/ps2mouse_ctrl.sv
// Host-side PS/2 mouse sequencer: bring-up dialogue with timeouts and bounded retries,
// 3-byte stream packet assembly and a clamped screen-space cursor.
module ps2mouse_ctrl #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iRestart,
    output logic        oTxValid,
    output logic [7:0]  oTxData,
    input  logic        iTxReady,
    input  logic        iRxValid,
    input  logic [7:0]  iRxData,
    input  logic        iRxErr,
    output logic        oReady,
    output logic        oFail,
    output logic        oTrig,
    output logic [15:0] Xpos,
    output logic [15:0] Ypos,
    output logic [7:0]  key_down
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    localparam logic [15:0]        X_HOME  = 16'(X_MAX >> 1);
    localparam logic [15:0]        Y_HOME  = 16'(Y_MAX >> 1);
    localparam logic [15:0]        X_CLAMP = 16'(X_MAX);
    localparam logic [15:0]        Y_CLAMP = 16'(Y_MAX);
    localparam logic signed [16:0] X_LIM   = 17'(X_MAX);
    localparam logic signed [16:0] Y_LIM   = 17'(Y_MAX);

    typedef enum logic [2:0] {
        S_TX_RST,
        S_ACK_RST,
        S_BAT,
        S_ID,
        S_TX_EN,
        S_ACK_EN,
        S_STREAM,
        S_FAIL
    } state_t;

    // Byte 0 of a stream packet without its always-one sync bit.
    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] btn;
    } hdr_t;

    state_t          r_state;
    state_t          w_state_next;
    state_t          w_adv_state;
    logic            r_tx_valid;
    logic [TW-1:0]   r_timer;
    logic [RW-1:0]   r_retry;
    logic [RW-1:0]   w_retry_next;
    logic            r_restart_pend;
    logic [1:0]      r_byte_idx;
    hdr_t            r_hdr;
    logic [7:0]      r_b1;
    logic [15:0]     r_x;
    logic [15:0]     r_y;
    logic [2:0]      r_btn;
    logic            r_trig;

    logic            w_accept;
    logic            w_restart_go;
    logic            w_tmo;
    logic            w_wait_state;
    logic            w_fail;
    logic            w_resend;
    logic [7:0]      w_expect;
    logic            w_in_stream;
    logic            w_pkt_done;
    logic signed [16:0] w_dx;
    logic signed [16:0] w_dy;
    logic signed [16:0] w_x_sum;
    logic signed [16:0] w_y_sum;
    logic [15:0]     w_x_new;
    logic [15:0]     w_y_new;

    assign w_accept     = r_tx_valid & iTxReady;
    // A pending restart never abandons a byte the transceiver has not yet taken.
    assign w_restart_go = r_restart_pend & (~r_tx_valid | iTxReady);
    assign w_tmo        = (r_timer == TMO_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_retry_next = r_retry;
        w_adv_state  = r_state;
        w_expect     = RSP_ACK;
        w_wait_state = 1'b0;
        w_fail       = 1'b0;
        w_resend     = 1'b0;

        case (r_state)
            S_TX_RST:  if (w_accept) w_state_next = S_ACK_RST;
            S_TX_EN:   if (w_accept) w_state_next = S_ACK_EN;
            S_ACK_RST: begin w_wait_state = 1'b1; w_expect = RSP_ACK;    w_adv_state = S_BAT;    end
            S_BAT:     begin w_wait_state = 1'b1; w_expect = RSP_BAT_OK; w_adv_state = S_ID;     end
            S_ID:      begin w_wait_state = 1'b1; w_expect = RSP_ID;     w_adv_state = S_TX_EN;  end
            S_ACK_EN:  begin w_wait_state = 1'b1; w_expect = RSP_ACK;    w_adv_state = S_STREAM; end
            default:   ;
        endcase

        if (w_wait_state) begin
            if (iRxErr) begin
                w_fail = 1'b1;
            end else if (iRxValid) begin
                if (iRxData == w_expect) begin
                    w_state_next = w_adv_state;
                end else begin
                    w_fail   = 1'b1;
                    w_resend = (iRxData == RSP_RESEND) &&
                               (r_state == S_ACK_RST || r_state == S_ACK_EN);
                end
            end else if (w_tmo) begin
                w_fail = 1'b1;
            end
        end

        if (w_fail) begin
            if (r_retry == RETRY_LAST) begin
                w_state_next = S_FAIL;
            end else begin
                w_retry_next = r_retry + RW'(1);
                w_state_next = (w_resend && r_state == S_ACK_EN) ? S_TX_EN : S_TX_RST;
            end
        end

        if (w_restart_go) begin
            w_state_next = S_TX_RST;
            w_retry_next = '0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state        <= S_TX_RST;
            r_retry        <= '0;
            r_tx_valid     <= 1'b0;
            r_restart_pend <= 1'b0;
            r_timer        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state    <= w_state_next;
            r_retry    <= w_retry_next;
            r_tx_valid <= (w_state_next == S_TX_RST) || (w_state_next == S_TX_EN);

            if (iRestart)
                r_restart_pend <= 1'b1;
            else if (w_restart_go)
                r_restart_pend <= 1'b0;

            // One timer serves both the response wait and the stream inter-byte gap.
            if (w_state_next != r_state || w_restart_go)
                r_timer <= '0;
            else if (r_state == S_STREAM && (iRxValid || iRxErr))
                r_timer <= '0;
            else if (!w_tmo)
                r_timer <= r_timer + TW'(1);
        end
    end

    assign w_in_stream = (r_state == S_STREAM) && !w_restart_go;
    assign w_pkt_done  = w_in_stream && iRxValid && !iRxErr && (r_byte_idx == 2'd2);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_byte_idx <= 2'd0;
            r_hdr      <= '0;
            r_b1       <= 8'h00;
        end else if (!w_in_stream) begin
            r_byte_idx <= 2'd0;
        end else if (iRxErr) begin
            r_byte_idx <= 2'd0;
        end else if (iRxValid) begin
            case (r_byte_idx)
                2'd0: begin
                    if (iRxData[3]) begin
                        r_hdr      <= {iRxData[7:4], iRxData[2:0]};
                        r_byte_idx <= 2'd1;
                    end
                end
                2'd1: begin
                    r_b1       <= iRxData;
                    r_byte_idx <= 2'd2;
                end
                default: r_byte_idx <= 2'd0;
            endcase
        end else if (w_tmo && r_byte_idx != 2'd0) begin
            r_byte_idx <= 2'd0;
        end
    end

    // The third byte is consumed straight from iRxData so the update lands on the next edge.
    always_comb begin
        w_dx    = r_hdr.x_ovf ? 17'sd0 : {{8{r_hdr.x_sign}}, r_hdr.x_sign, r_b1};
        w_dy    = r_hdr.y_ovf ? 17'sd0 : {{8{r_hdr.y_sign}}, r_hdr.y_sign, iRxData};
        w_x_sum = $signed({1'b0, r_x}) + w_dx;
        w_y_sum = $signed({1'b0, r_y}) - w_dy;

        if (w_x_sum[16])
            w_x_new = 16'd0;
        else if (w_x_sum > X_LIM)
            w_x_new = X_CLAMP;
        else
            w_x_new = w_x_sum[15:0];

        if (w_y_sum[16])
            w_y_new = 16'd0;
        else if (w_y_sum > Y_LIM)
            w_y_new = Y_CLAMP;
        else
            w_y_new = w_y_sum[15:0];
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        // NOTE: the cursor registers take reset values, so position is defined before any packet.
        if (RESET) begin
            r_x    <= X_HOME;
            r_y    <= Y_HOME;
            r_btn  <= 3'b000;
            r_trig <= 1'b0;
        end else begin
            r_trig <= w_pkt_done;
            if (w_pkt_done) begin
                r_x   <= w_x_new;
                r_y   <= w_y_new;
                r_btn <= r_hdr.btn;
            end
        end
    end

    assign oTxValid = r_tx_valid;
    assign oTxData  = (r_state == S_TX_EN) ? CMD_ENABLE : CMD_RESET;
    assign oReady   = (r_state == S_STREAM);
    assign oFail    = (r_state == S_FAIL);
    assign oTrig    = r_trig;
    assign Xpos     = r_x;
    assign Ypos     = r_y;
    assign key_down = {5'b00000, r_btn};

endmodule

// File: tb/tb_ps2mouse_ctrl.sv
// Bench for ps2mouse_ctrl: directed bring-up/retry scenarios plus randomized stream
// traffic checked against an integer cursor model.
module tb_ps2mouse_ctrl;

    localparam int T  = 300;
    localparam int MR = 2;
    localparam int XM = 639;
    localparam int YM = 479;

    logic        CLOCK;
    logic        RESET;
    logic        iRestart;
    logic        iTxReady;
    logic        iRxValid;
    logic        iRxErr;
    logic [7:0]  iRxData;
    logic        oTxValid;
    logic [7:0]  oTxData;
    logic        oReady;
    logic        oFail;
    logic        oTrig;
    logic [15:0] Xpos;
    logic [15:0] Ypos;
    logic [7:0]  key_down;

    ps2mouse_ctrl #(
        .TIMEOUT_CYCLES(T),
        .MAX_RETRY     (MR),
        .X_MAX         (XM),
        .Y_MAX         (YM)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .iRestart(iRestart),
        .oTxValid(oTxValid),
        .oTxData (oTxData),
        .iTxReady(iTxReady),
        .iRxValid(iRxValid),
        .iRxData (iRxData),
        .iRxErr  (iRxErr),
        .oReady  (oReady),
        .oFail   (oFail),
        .oTrig   (oTrig),
        .Xpos    (Xpos),
        .Ypos    (Ypos),
        .key_down(key_down)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;
    int mx;
    int my;
    int mk;
    int trig_cnt = 0;
    logic [7:0] tx_log[$];

    always @(posedge CLOCK) begin
        if (!RESET && oTxValid && iTxReady) tx_log.push_back(oTxData);
        if (!RESET && oTrig) trig_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic void model_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] b2);
        int dx;
        int dy;
        dx = b0[6] ? 0 : (int'(b1) - (b0[4] ? 256 : 0));
        dy = b0[7] ? 0 : (int'(b2) - (b0[5] ? 256 : 0));
        mx = clampi(mx + dx, XM);
        my = clampi(my - dy, YM);
        mk = int'(b0[2:0]);
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        iRxData  = b;
        iRxValid = 1'b1;
        tick();
        iRxValid = 1'b0;
    endtask

    task automatic rx_err_pulse();
        iRxErr = 1'b1;
        tick();
        iRxErr = 1'b0;
    endtask

    task automatic rx_both(input logic [7:0] b);
        iRxData  = b;
        iRxValid = 1'b1;
        iRxErr   = 1'b1;
        tick();
        iRxValid = 1'b0;
        iRxErr   = 1'b0;
    endtask

    task automatic pulse_restart();
        iRestart = 1'b1;
        tick();
        iRestart = 1'b0;
    endtask

    task automatic wait_tx(input logic [7:0] exp, input string tag);
        int k;
        int d;
        k = 0;
        while (oTxValid !== 1'b1 && k < 4 * T) begin
            tick();
            k++;
        end
        if (oTxValid !== 1'b1) begin
            chk({tag, "_tx_seen"}, 32'(oTxValid), 32'd1);
            return;
        end
        d = $urandom_range(0, 3);
        repeat (d) tick();
        chk({tag, "_tx_hold"}, 32'(oTxValid), 32'd1);
        chk({tag, "_tx_data"}, 32'(oTxData), 32'(exp));
        iTxReady = 1'b1;
        tick();
        iTxReady = 1'b0;
        chk({tag, "_tx_drop"}, 32'(oTxValid), 32'd0);
    endtask

    task automatic nominal_init(input string tag);
        int n0;
        n0 = tx_log.size();
        wait_tx(8'hFF, {tag, "_ff"});
        idle($urandom_range(0, 4));
        rx_byte(8'hFA);
        idle($urandom_range(0, 4));
        rx_byte(8'hAA);
        idle($urandom_range(0, 4));
        rx_byte(8'h00);
        wait_tx(8'hF4, {tag, "_f4"});
        idle($urandom_range(0, 4));
        chk({tag, "_ready_before"}, 32'(oReady), 32'd0);
        rx_byte(8'hFA);
        chk({tag, "_ready"}, 32'(oReady), 32'd1);
        chk({tag, "_fail"}, 32'(oFail), 32'd0);
        chk({tag, "_tx_count"}, 32'(tx_log.size() - n0), 32'd2);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int gmax, input int t0, input string tag);
        model_pkt(b0, b1, b2);
        rx_byte(b0);
        idle($urandom_range(0, gmax));
        rx_byte(b1);
        idle($urandom_range(0, gmax));
        rx_byte(b2);
        chk({tag, "_trig"}, 32'(oTrig), 32'd1);
        chk({tag, "_x"}, 32'(Xpos), 32'(mx));
        chk({tag, "_y"}, 32'(Ypos), 32'(my));
        chk({tag, "_keys"}, 32'(key_down), 32'(mk));
        tick();
        chk({tag, "_trig_off"}, 32'(oTrig), 32'd0);
        chk({tag, "_trig_count"}, 32'(trig_cnt - t0), 32'd1);
    endtask

    initial begin
        int k;
        int t0;
        int n0;
        int kind;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;

        RESET    = 1'b1;
        iRestart = 1'b0;
        iTxReady = 1'b0;
        iRxValid = 1'b0;
        iRxErr   = 1'b0;
        iRxData  = 8'h00;
        mx = XM >> 1;
        my = YM >> 1;
        mk = 0;

        // Reset values.
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_txvalid", 32'(oTxValid), 32'd0);
        chk("rst_txdata", 32'(oTxData), 32'hFF);
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_fail", 32'(oFail), 32'd0);
        chk("rst_trig", 32'(oTrig), 32'd0);
        chk("rst_x", 32'(Xpos), 32'd319);
        chk("rst_y", 32'(Ypos), 32'd239);
        chk("rst_keys", 32'(key_down), 32'd0);
        RESET = 1'b0;
        tick();
        chk("first_txvalid", 32'(oTxValid), 32'd1);

        // Nominal bring-up and the directed packets.
        nominal_init("init");
        t0 = trig_cnt;
        send_pkt(8'h09, 8'h05, 8'h03, 2, t0, "pkt1");
        chk("pkt1_x_abs", 32'(Xpos), 32'd324);
        chk("pkt1_y_abs", 32'(Ypos), 32'd236);
        t0 = trig_cnt;
        send_pkt(8'h18, 8'h00, 8'h00, 2, t0, "clamp1");
        chk("clamp1_x_abs", 32'(Xpos), 32'd68);
        t0 = trig_cnt;
        send_pkt(8'h18, 8'h00, 8'h00, 2, t0, "clamp2");
        chk("clamp2_x_abs", 32'(Xpos), 32'd0);
        chk("clamp2_y_abs", 32'(Ypos), 32'd236);

        t0 = trig_cnt;
        rx_byte(8'h00);
        send_pkt(8'h08, 8'h00, 8'hF0, 2, t0, "resync");
        chk("resync_y_abs", 32'(Ypos), 32'd0);

        t0 = trig_cnt;
        rx_byte(8'h09);
        rx_byte(8'h05);
        rx_err_pulse();
        send_pkt(8'h28, 8'h10, 8'h20, 2, t0, "err_mid");

        // Randomized stream traffic with framing noise.
        for (int i = 0; i < 30; i++) begin
            b0   = 8'($urandom) | 8'h08;
            b1   = 8'($urandom);
            b2   = 8'($urandom);
            kind = $urandom_range(0, 9);
            t0   = trig_cnt;
            case (kind)
                0: rx_byte(8'($urandom) & 8'hF7);
                1: begin
                    rx_byte(8'($urandom) | 8'h08);
                    if ($urandom_range(0, 1) == 1) rx_byte(8'($urandom));
                    rx_err_pulse();
                end
                2: rx_both(8'($urandom) | 8'h08);
                3: begin
                    rx_byte(8'($urandom) | 8'h08);
                    idle(T + 5);
                end
                default: ;
            endcase
            send_pkt(b0, b1, b2, (kind == 4) ? T / 2 : 3, t0, $sformatf("rnd%0d_k%0d", i, kind));
        end

        // Restart from STREAM; junk in a TX state; 0xFE re-sends the enable command.
        n0 = tx_log.size();
        pulse_restart();
        wait_tx(8'hFF, "rs_ff");
        chk("rs_ready_drop", 32'(oReady), 32'd0);
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        rx_byte(8'h12);
        wait_tx(8'hF4, "rs_f4a");
        rx_byte(8'hFE);
        chk("rs_resend_valid", 32'(oTxValid), 32'd1);
        chk("rs_resend_data", 32'(oTxData), 32'hF4);
        wait_tx(8'hF4, "rs_f4b");
        rx_byte(8'hFA);
        chk("rs_ready", 32'(oReady), 32'd1);
        chk("rs_tx_count", 32'(tx_log.size() - n0), 32'd3);
        chk("rs_x_kept", 32'(Xpos), 32'(mx));

        // Wrong byte, error strobe, then a resend with retries exhausted.
        pulse_restart();
        wait_tx(8'hFF, "wb_ff1");
        rx_byte(8'hFA);
        rx_byte(8'h55);
        chk("wb_retry1", 32'(oTxValid), 32'd1);
        wait_tx(8'hFF, "wb_ff2");
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_err_pulse();
        chk("wb_retry2", 32'(oTxValid), 32'd1);
        wait_tx(8'hFF, "wb_ff3");
        rx_byte(8'hFA);
        rx_byte(8'hAA);
        rx_byte(8'h00);
        wait_tx(8'hF4, "wb_f4");
        rx_byte(8'hFE);
        chk("wb_fail", 32'(oFail), 32'd1);
        chk("wb_fail_txvalid", 32'(oTxValid), 32'd0);

        // Silent device: each wait lasts T cycles, MR+1 attempts, then FAIL.
        n0 = tx_log.size();
        pulse_restart();
        for (int a = 0; a <= MR; a++) begin
            wait_tx(8'hFF, $sformatf("to%0d", a));
            k = 0;
            while (oTxValid !== 1'b1 && oFail !== 1'b1 && k < 4 * T) begin
                tick();
                k++;
            end
            chk($sformatf("to%0d_cycles", a), 32'(k), 32'(T));
            if (a < MR) chk($sformatf("to%0d_retry", a), 32'(oTxValid), 32'd1);
            else        chk($sformatf("to%0d_fail", a), 32'(oFail), 32'd1);
        end
        chk("to_tx_count", 32'(tx_log.size() - n0), 32'(MR + 1));
        chk("to_ready", 32'(oReady), 32'd0);
        idle(50);
        chk("to_fail_hold", 32'(oFail), 32'd1);
        chk("to_txvalid_hold", 32'(oTxValid), 32'd0);

        // Recovery after FAIL keeps the cursor.
        pulse_restart();
        nominal_init("recover");
        chk("recover_x_kept", 32'(Xpos), 32'(mx));
        chk("recover_y_kept", 32'(Ypos), 32'(my));

        // Reset in the middle of a packet.
        t0 = trig_cnt;
        send_pkt(8'h18, 8'h00, 8'h00, 2, t0, "prerst1");
        t0 = trig_cnt;
        send_pkt(8'h18, 8'h00, 8'h00, 2, t0, "prerst2");
        rx_byte(8'h09);
        RESET = 1'b1;
        #1;
        chk("midrst_x", 32'(Xpos), 32'd319);
        chk("midrst_y", 32'(Ypos), 32'd239);
        chk("midrst_keys", 32'(key_down), 32'd0);
        chk("midrst_txvalid", 32'(oTxValid), 32'd0);
        chk("midrst_ready", 32'(oReady), 32'd0);
        tick();
        RESET = 1'b0;
        mx = XM >> 1;
        my = YM >> 1;
        mk = 0;
        nominal_init("postrst");
        t0 = trig_cnt;
        send_pkt(8'h09, 8'h05, 8'h03, 2, t0, "postrst_pkt");
        chk("postrst_x_abs", 32'(Xpos), 32'd324);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
